irda_wb_arbiter: RTL and testbench
==================================

# irda_wb_arbiter

Two-master Wishbone arbiter sharing the single IrDA register/data slave port between the host CPU (master 0) and the IrDA DMA engine (master 1). It grants the slave port round-robin, holds a grant for the whole `cyc` cycle, and routes the slave's acknowledge and read data back to the granted master only. An optional watchdog terminates transfers the slave never acknowledges.

## Interface
Parameters:
- `AW`, 4, address width.
- `DW`, 32, data width.
- `TO_CYCLES`, 15, watchdog limit in clocks, valid range 2..255 (8-bit counter).

Ports, where `mN` means one port each for `m0` and `m1`:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `mN_cyc_i`  in  1  master N bus request / cycle.
- `mN_stb_i`  in  1  master N strobe.
- `mN_we_i`  in  1  master N write enable.
- `mN_adr_i`  in  AW  master N address.
- `mN_dat_i`  in  DW  master N write data.
- `mN_dat_o`  out  DW  read data to master N.
- `mN_ack_o`  out  1  acknowledge to master N.
- `mN_err_o`  out  1  watchdog error to master N.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave-side cycle, strobe and write enable.
- `s_adr_o`  out  AW  slave address.
- `s_dat_o`  out  DW  slave write data.
- `s_dat_i`  in  DW  slave read data.
- `s_ack_i`  in  1  slave acknowledge. The slave registers this one clock after it sees `stb & cyc`.
- `gnt_o`  out  2  one-hot grant. `01` grants m0, `10` grants m1, `00` means idle.

## Operation
- FSM states: IDLE, GNT0, GNT1. A 1-bit priority pointer `last` records the master served most recently.
- **IDLE**
  - Only one `mN_cyc_i` high: go to GNTN.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in IDLE.
- **GNTN**
  - Stay while `mN_cyc_i` is high. The grant is locked, so the other master waits regardless of its request.
  - When `mN_cyc_i` is low, set `last`=N. If the other master's `cyc` is high, go directly to its grant state with no dead cycle. Otherwise go to IDLE.
- **Slave-side mux (combinational from the registered state)**
  - Slave signals are driven from the granted master.
  - In IDLE, `s_cyc_o`/`s_stb_o`/`s_we_o` are 0 and `s_adr_o`/`s_dat_o` are 0.
- **Return path**
  - `mN_ack_o` = `s_ack_i` & grant N.
  - `mN_dat_o` = `s_dat_i` when granted, else 0.
  - The non-granted master never sees ack, err or data.
- **Reset**
  - State goes to IDLE and `last`=1, so m0 wins the first simultaneous request.
  - The watchdog counter clears, and all outputs go to 0 (`gnt_o`=00).
  - A reset asserted mid-transfer drops the grant on the next edge. No ack is forwarded afterward.

## Timing
- Request latency:
  - Cycle 0: `mN_cyc_i`/`stb_i` rise.
  - Cycle 1: grant registered, `s_stb_o` high.
  - Cycle 2: `s_ack_i` arrives and `mN_ack_o` high in the same cycle.
  - Minimum single transfer is 2 clocks from request to ack.
- Handoff: after the granted master drops `cyc` in cycle k, the other master's `s_stb_o` appears in cycle k+1.
- Simultaneous "current master drops `cyc`" and "other master raises `cyc`" in the same cycle: handoff occurs, no idle cycle.
- A master holding `cyc` with `stb` low keeps the grant indefinitely. The watchdog counts only while `stb` is high.

## Configuration
- Macro: `IRDA_ARB_WATCHDOG_EN`.
- **Defined:**
  - An 8-bit counter increments each clock while the granted master has `stb` high and `s_ack_i` is low, and clears on ack, on grant change, and on reset.
  - When the count reaches `TO_CYCLES`, the arbiter:
    - pulses `mN_err_o` for exactly 1 clock;
    - forces `s_stb_o` and `s_cyc_o` low in that cycle;
    - clears the counter;
    - handles the next transition exactly as if `mN_cyc_i` had dropped (pointer update, handoff).
  - If the master still holds `cyc`, it is eligible again only after the other master is served, or next in IDLE.
- **Not defined:** no counter logic. Both `err_o` outputs are tied 0 and a hung slave holds the grant forever.

## Test plan
- Reset, then m0 writes address 0x3 with data 0xA5: `gnt_o`=01 at cycle 1, `s_adr_o`=0x3, `s_dat_o`=0xA5, `m0_ack_o` at cycle 2, and `m1_ack_o` stays 0.
- Both masters request in the same cycle right after reset: m0 is granted first. After m0 drops `cyc`, `gnt_o`=10 on the very next clock, then a read returns `s_dat_i`=0x1234 on `m1_dat_o` and `m0_dat_o`=0.
- m1 holds `cyc` for 3 back-to-back transfers while m0 requests: m0 gets no grant until m1 releases. `last`=1, so the next simultaneous request goes to m0.
- With `IRDA_ARB_WATCHDOG_EN` and `TO_CYCLES`=4, `s_ack_i` held 0: `m0_err_o` pulses once, `TO_CYCLES` clocks after the first clock `s_stb_o` is high, and `s_stb_o` is low in the err cycle. A pending m1 is granted the next clock.
- Assert `wb_rst_i` for one clock while GNT1 has `stb` high: all outputs are 0 after the edge, `gnt_o`=00, and no `m1_ack_o` appears even if `s_ack_i` pulses.

Source files
------------

// File: rtl/irda_wb_arbiter.sv
// ============================================================================
// irda_wb_arbiter
//
// Two-master Wishbone arbiter for the IrDA register/data slave port.
// Master 0 is the host CPU and master 1 is the IrDA DMA engine. Grants are
// round-robin. A grant is held for the whole cyc cycle. The slave's
// ack/data/err go back to the granted master only.
//
// Optional feature (macro IRDA_ARB_WATCHDOG_EN):
//   An 8-bit watchdog terminates a transfer that the slave has not acked
//   within TO_CYCLES clocks of strobe. It pulses the master's err_o, drops
//   s_cyc_o/s_stb_o for that clock, and releases the grant. Without the
//   macro, both err_o outputs are tied low.
//
// Parameters:
//   AW        address width
//   DW        data width
//   TO_CYCLES watchdog limit in clocks (2..255)
//
// Ports:
//   clk, wb_rst_i                 clock, synchronous active-high reset
//   mN_cyc_i/stb_i/we_i/adr_i/dat_i   master N request side (N = 0, 1)
//   mN_dat_o/ack_o/err_o          master N return side
//   s_cyc_o/stb_o/we_o/adr_o/dat_o    slave request side
//   s_dat_i, s_ack_i              slave return side
//   gnt_o                         one-hot grant (01 = m0, 10 = m1, 00 = idle)
// ============================================================================
module irda_wb_arbiter #(
    parameter int AW        = 4,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 15
) (
    input  logic          clk,
    input  logic          wb_rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TO_CYCLES);

    state_t        state_q, state_d;
    logic          last_q, last_d;   // master served most recently
    logic [1:0]    gnt;
    logic [1:0]    stb_in;
    logic [1:0]    ack;
    logic [1:0]    err;
    logic [DW-1:0] mdat [2];
    logic          timeout;

    assign stb_in = {m1_stb_i, m0_stb_i};
    assign gnt    = {state_q == ST_GNT1, state_q == ST_GNT0};
    assign gnt_o  = gnt;

`ifdef IRDA_ARB_WATCHDOG_EN
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       gnt_stb;

    assign gnt_stb = |(gnt & stb_in);
    assign timeout = (state_q != ST_IDLE) && (wd_cnt_q == TO_LIMIT);

    // The counter restarts on any grant change. This keeps a stale count
    // from one master from shortening the next master's window.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (timeout || (state_d != state_q) || s_ack_i) begin
            wd_cnt_d = '0;
        end else if (gnt_stb) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic unused_to_limit;
    assign unused_to_limit = ^TO_LIMIT;
    assign timeout         = 1'b0;
`endif

    // Grant FSM. A timeout is treated exactly like the owner dropping cyc,
    // so a hung owner goes to the back of the round-robin order.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc_i) begin
                    state_d = ST_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i || timeout) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i || timeout) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;   // m0 wins the first contested request
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Slave-side mux, driven from the registered grant
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state_q)
            ST_GNT0: begin
                s_cyc_o = m0_cyc_i & ~timeout;
                s_stb_o = m0_stb_i & ~timeout;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            ST_GNT1: begin
                s_cyc_o = m1_cyc_i & ~timeout;
                s_stb_o = m1_stb_i & ~timeout;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    // Return path: only the granted master sees ack, err or data
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            assign ack[gi]  = s_ack_i & gnt[gi];
            assign err[gi]  = timeout & gnt[gi];
            assign mdat[gi] = gnt[gi] ? s_dat_i : '0;
        end
    endgenerate

    assign m0_ack_o = ack[0];
    assign m1_ack_o = ack[1];
    assign m0_err_o = err[0];
    assign m1_err_o = err[1];
    assign m0_dat_o = mdat[0];
    assign m1_dat_o = mdat[1];

endmodule

// File: tb/tb_irda_wb_arbiter.sv
// ============================================================================
// tb_irda_wb_arbiter
//
// Directed testbench for irda_wb_arbiter. Inputs change on the falling edge.
// Outputs are checked 1 ns later, well away from the rising edge. The DUT is
// built with TO_CYCLES = 4. The watchdog scenario checks a timeout when
// IRDA_ARB_WATCHDOG_EN is defined. Otherwise it checks that the grant is held.
// ============================================================================
module tb_irda_wb_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          wb_rst_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    irda_wb_arbiter #(.AW(AW), .DW(DW), .TO_CYCLES(4)) dut (
        .clk(clk), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0;
        s_ack_i  = 1'b0; s_dat_i  = '0;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        idle_inputs();
        nxt();
        nxt();
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 4'h7; m0_dat_i = 32'h77;
        s_ack_i  = 1'b1; s_dat_i  = 32'hFFFF;
        nxt(); nxt(); #1;
        n_cmp++;
        if ({gnt_o, s_cyc_o, s_stb_o, s_we_o} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got gnt/cyc/stb/we=%b expected 00000",
                     {gnt_o, s_cyc_o, s_stb_o, s_we_o});
        end
        n_cmp++;
        if ({s_adr_o, s_dat_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: got adr=%h dat=%h expected 0", s_adr_o, s_dat_o);
        end
        n_cmp++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_ret: got acks=%b%b errs=%b%b d0=%h d1=%h expected all 0",
                     m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o);
        end
        $display("reset: outputs checked idle");
        idle_inputs();
        wb_rst_i = 1'b0;
        nxt();
    endtask

    task automatic test_single_write();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 4'h3; m0_dat_i = 32'hA5;
        #1;
        n_cmp++;
        if (gnt_o !== 2'b00) begin
            n_bad++; $display("FAIL wr_cycle0_gnt: got %b expected 00", gnt_o);
        end
        nxt(); #1;
        n_cmp++;
        if ({gnt_o, s_cyc_o, s_stb_o, s_we_o} !== 5'b01111) begin
            n_bad++;
            $display("FAIL wr_cycle1_ctrl: got %b expected 01111", {gnt_o, s_cyc_o, s_stb_o, s_we_o});
        end
        n_cmp++;
        if (s_adr_o !== 4'h3 || s_dat_o !== 32'hA5) begin
            n_bad++; $display("FAIL wr_bus: got adr=%h dat=%h expected 3/a5", s_adr_o, s_dat_o);
        end
        nxt(); s_ack_i = 1'b1; #1;
        n_cmp++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
            n_bad++; $display("FAIL wr_ack: got m0/m1 ack=%b%b expected 10", m0_ack_o, m1_ack_o);
        end
        $display("m0 write adr=3 dat=a5 ack=%b", m0_ack_o);
        nxt(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; #1;
        n_cmp++;
        if ({gnt_o, s_cyc_o} !== 3'b010) begin
            n_bad++; $display("FAIL wr_drop: got gnt/cyc=%b expected 010", {gnt_o, s_cyc_o});
        end
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b00) begin
            n_bad++; $display("FAIL wr_idle: got gnt=%b expected 00", gnt_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 4'h1; m0_dat_i = 32'h11;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 4'h5;
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b01 || s_adr_o !== 4'h1) begin
            n_bad++; $display("FAIL sim_first: got gnt=%b adr=%h expected 01/1", gnt_o, s_adr_o);
        end
        nxt(); s_ack_i = 1'b1; #1;
        n_cmp++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
            n_bad++; $display("FAIL sim_ack0: got %b%b expected 10", m0_ack_o, m1_ack_o);
        end
        $display("m0 write adr=1 (contested) ack=%b", m0_ack_o);
        nxt(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; #1;
        n_cmp++;
        if (gnt_o !== 2'b01) begin
            n_bad++; $display("FAIL sim_hold: got gnt=%b expected 01", gnt_o);
        end
        nxt(); #1;
        n_cmp++;
        if ({gnt_o, s_stb_o, s_we_o} !== 4'b1010 || s_adr_o !== 4'h5) begin
            n_bad++;
            $display("FAIL sim_handoff: got gnt/stb/we=%b adr=%h expected 1010/5",
                     {gnt_o, s_stb_o, s_we_o}, s_adr_o);
        end
        nxt(); s_ack_i = 1'b1; s_dat_i = 32'h1234; #1;
        n_cmp++;
        if (m1_dat_o !== 32'h1234 || m0_dat_o !== 32'h0 || {m0_ack_o, m1_ack_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL sim_read: got d1=%h d0=%h acks=%b%b expected 1234/0/01",
                     m1_dat_o, m0_dat_o, m0_ack_o, m1_ack_o);
        end
        $display("m1 read adr=5 dat=%h", m1_dat_o);
        nxt(); idle_inputs();
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b00) begin
            n_bad++; $display("FAIL sim_idle: got gnt=%b expected 00", gnt_o);
        end
    endtask

    task automatic test_lock();
        do_reset();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 4'h7;
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b10) begin
            n_bad++; $display("FAIL lock_gnt1: got %b expected 10", gnt_o);
        end
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 4'h2;
        for (int i = 0; i < 3; i++) begin
            nxt(); s_ack_i = 1'b1; s_dat_i = 32'(100 + i); #1;
            n_cmp++;
            if (gnt_o !== 2'b10 || {m0_ack_o, m1_ack_o} !== 2'b01 ||
                m1_dat_o !== 32'(100 + i) || m0_dat_o !== 32'h0) begin
                n_bad++;
                $display("FAIL lock_xfer%0d: got gnt=%b acks=%b%b d1=%h d0=%h expected 10/01/%h/0",
                         i, gnt_o, m0_ack_o, m1_ack_o, m1_dat_o, m0_dat_o, 32'(100 + i));
            end
            $display("m1 burst beat %0d dat=%h", i, m1_dat_o);
            nxt(); s_ack_i = 1'b0; #1;
            n_cmp++;
            if (gnt_o !== 2'b10) begin
                n_bad++; $display("FAIL lock_hold%0d: got gnt=%b expected 10", i, gnt_o);
            end
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b01 || s_stb_o !== 1'b1 || s_adr_o !== 4'h2) begin
            n_bad++;
            $display("FAIL lock_release: got gnt=%b stb=%b adr=%h expected 01/1/2", gnt_o, s_stb_o, s_adr_o);
        end
        nxt(); s_ack_i = 1'b1; #1;
        $display("m0 transfer after m1 release ack=%b", m0_ack_o);
        // m0 drops while m1 raises in the same cycle: no idle gap expected
        nxt(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 4'h9;
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b10 || s_adr_o !== 4'h9) begin
            n_bad++; $display("FAIL lock_swap: got gnt=%b adr=%h expected 10/9", gnt_o, s_adr_o);
        end
        nxt(); s_ack_i = 1'b1; #1;
        $display("m1 transfer adr=9 ack=%b", m1_ack_o);
        nxt(); s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        nxt();
        // last = 1 now, so a contested request must go to m0
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 4'h4;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 4'h6;
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b01 || s_adr_o !== 4'h4) begin
            n_bad++; $display("FAIL lock_rr: got gnt=%b adr=%h expected 01/4", gnt_o, s_adr_o);
        end
        idle_inputs();
        nxt(); nxt();
    endtask

    task automatic test_watchdog();
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 4'h3;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 4'h5;
        for (int c = 1; c <= 4; c++) begin
            nxt(); #1;
            n_cmp++;
            if (gnt_o !== 2'b01 || s_stb_o !== 1'b1 || m0_err_o !== 1'b0) begin
                n_bad++;
                $display("FAIL wd_wait%0d: got gnt=%b stb=%b err=%b expected 01/1/0",
                         c, gnt_o, s_stb_o, m0_err_o);
            end
        end
        nxt(); #1;
`ifdef IRDA_ARB_WATCHDOG_EN
        n_cmp++;
        if ({m0_err_o, m1_err_o, s_stb_o, s_cyc_o} !== 4'b1000 || gnt_o !== 2'b01) begin
            n_bad++;
            $display("FAIL wd_err: got err0/err1/stb/cyc=%b gnt=%b expected 1000/01",
                     {m0_err_o, m1_err_o, s_stb_o, s_cyc_o}, gnt_o);
        end
        $display("m0 timeout err=%b", m0_err_o);
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b10 || m0_err_o !== 1'b0 || s_adr_o !== 4'h5) begin
            n_bad++;
            $display("FAIL wd_handoff: got gnt=%b err0=%b adr=%h expected 10/0/5", gnt_o, m0_err_o, s_adr_o);
        end
`else
        n_cmp++;
        if ({m0_err_o, m1_err_o, s_stb_o, s_cyc_o} !== 4'b0011) begin
            n_bad++;
            $display("FAIL wd_off: got err0/err1/stb/cyc=%b expected 0011", {m0_err_o, m1_err_o, s_stb_o, s_cyc_o});
        end
        $display("m0 hung transfer still granted, err=%b", m0_err_o);
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b01) begin
            n_bad++; $display("FAIL wd_off_hold: got gnt=%b expected 01", gnt_o);
        end
`endif
        idle_inputs();
        nxt();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 4'h8; m1_dat_i = 32'h55;
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b10 || s_stb_o !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_pre: got gnt=%b stb=%b expected 10/1", gnt_o, s_stb_o);
        end
        wb_rst_i = 1'b1;
        nxt(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD; #1;
        n_cmp++;
        if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m0_ack_o} !== 7'b0) begin
            n_bad++;
            $display("FAIL rst_mid_ctrl: got gnt/cyc/stb/we/ack1/ack0=%b expected 0",
                     {gnt_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m0_ack_o});
        end
        n_cmp++;
        if ({s_adr_o, s_dat_o, m1_dat_o} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_bus: got adr=%h dat=%h d1=%h expected 0", s_adr_o, s_dat_o, m1_dat_o);
        end
        $display("m1 transfer aborted by reset ack=%b", m1_ack_o);
        wb_rst_i = 1'b0;
        idle_inputs();
        nxt(); #1;
        n_cmp++;
        if (gnt_o !== 2'b00 || m1_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_after: got gnt=%b ack1=%b expected 00/0", gnt_o, m1_ack_o);
        end
    endtask

    initial begin
        wb_rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_simultaneous();
        test_lock();
        test_watchdog();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
